// File: rtl/fitness_pkg.sv
// Shared types for the workout controller: FSM phase encoding, timer states
// and small seconds-conversion helpers.
package fitness_pkg;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'b00,
    PH_WORKOUT = 2'b01,
    PH_REST    = 2'b10,
    PH_FINISH  = 2'b11
  } phase_e;

  typedef enum logic [1:0] {
    TS_STOP    = 2'b00,
    TS_RUN     = 2'b01,
    TS_PAUSED  = 2'b10,
    TS_EXPIRED = 2'b11
  } tstate_e;

  localparam logic [6:0] MAX_SECS = 7'd99;

  function automatic logic [6:0] sat99(input logic [7:0] v);
    return (v > 8'd99) ? MAX_SECS : v[6:0];
  endfunction

  // {tens, ones} of a 0..99 binary value
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [6:0] t, o;
    t = v / 7'd10;
    o = v - t * 7'd10;
    return {t[3:0], o[3:0]};
  endfunction

endpackage

// File: rtl/bcd2_down.sv
// Two-digit BCD down counter with a binary shadow; sync clear/load,
// decrement enable, sticks at 00.
module bcd2_down
  import fitness_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [6:0] load_val_i,
  input  logic       dec_i,
  output logic [6:0] bin_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic [6:0] bin_q, bin_d;
  logic [3:0] tens_q, tens_d, ones_q, ones_d;

  always_comb begin
    bin_d  = bin_q;
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr_i) begin
      bin_d  = '0;
      tens_d = '0;
      ones_d = '0;
    end else if (load_i) begin
      bin_d            = load_val_i;
      {tens_d, ones_d} = bin2bcd(load_val_i);
    end else if (dec_i && bin_q != '0) begin
      bin_d = bin_q - 7'd1;
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      bin_q  <= bin_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign bin_o  = bin_q;
  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

// File: rtl/interval_timer.sv
// Workout/rest interval countdown: reloads on a start rise or phase change,
// ticks once per second, flags the closing seconds and pulses on expiry.
module interval_timer
  import fitness_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int WARN_SECS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] phase,
  input  logic [7:0] work_secs,
  input  logic [7:0] rest_secs,
  input  logic       pause,
  output logic       time_done,
  output logic [6:0] remaining,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       warn,
  output logic       running
);

  localparam int         PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(CLK_HZ - 1);
  localparam logic [6:0] WARN_W  = 7'(WARN_SECS);

  tstate_e       state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          done_q, done_d;
  logic          start_prev_q, primed_q;
  logic [1:0]    phase_prev_q;
  logic          load_ev, tick, bcd_clr, bcd_load, bcd_dec;
  logic [6:0]    load_val;

  // The first cycle after reset only primes the edge history, so a start
  // level held across reset does not restart a discarded interval.
  assign load_ev = start_timer && primed_q &&
                   (!start_prev_q || phase != phase_prev_q);
  assign tick    = (state_q == TS_RUN) && (pre_q == PRE_TOP);

  always_comb begin
    case (phase_e'(phase))
      PH_WORKOUT: load_val = sat99(work_secs);
      PH_REST:    load_val = sat99(rest_secs);
      default:    load_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    done_d   = 1'b0;
    bcd_clr  = 1'b0;
    bcd_load = 1'b0;
    bcd_dec  = 1'b0;
    if (!start_timer) begin
      state_d = TS_STOP;
      pre_d   = '0;
      bcd_clr = 1'b1;
    end else if (load_ev) begin
      pre_d    = '0;
      bcd_load = 1'b1;
      if (load_val == '0) begin
        state_d = TS_EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = pause ? TS_PAUSED : TS_RUN;
      end
    end else begin
      case (state_q)
        TS_RUN: begin
          pre_d = tick ? '0 : pre_q + PW'(1);
          if (pause) state_d = TS_PAUSED;
          if (tick) begin
            bcd_dec = 1'b1;
            if (remaining == 7'd1) begin
              done_d  = 1'b1;
              state_d = TS_EXPIRED;
            end
          end
        end
        TS_PAUSED: if (!pause) state_d = TS_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= TS_STOP;
      pre_q        <= '0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b0;
      phase_prev_q <= 2'b00;
      primed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      done_q       <= done_d;
      start_prev_q <= start_timer;
      phase_prev_q <= phase;
      primed_q     <= 1'b1;
    end
  end

  bcd2_down u_bcd (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (bcd_clr),
    .load_i    (bcd_load),
    .load_val_i(load_val),
    .dec_i     (bcd_dec),
    .bin_o     (remaining),
    .tens_o    (sec_tens),
    .ones_o    (sec_ones)
  );

  assign time_done = done_q;
  assign running   = (state_q == TS_RUN);
  assign warn      = (state_q == TS_RUN || state_q == TS_PAUSED) &&
                     (remaining != '0) && (remaining <= WARN_W);

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench: a per-cycle seconds model predicts outputs as stimulus
// is driven; predictions are popped and compared after each clock edge.
module tb_interval_timer;
  import fitness_pkg::*;

  logic       clk = 1'b0, reset = 1'b1, start_timer = 1'b0, pause = 1'b0;
  logic [1:0] phase = 2'b00;
  logic [7:0] work_secs = '0, rest_secs = '0;
  logic       time_done, warn, running;
  logic [6:0] remaining;
  logic [3:0] sec_tens, sec_ones;

  interval_timer #(.CLK_HZ(4), .WARN_SECS(3)) dut (
    .clk(clk), .reset(reset), .start_timer(start_timer), .phase(phase),
    .work_secs(work_secs), .rest_secs(rest_secs), .pause(pause),
    .time_done(time_done), .remaining(remaining), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .warn(warn), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rem; int done; int warn; int run;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_err = 0;
  int ccount = 0, done_cyc = -1, pulses = 0;

  // reference model state
  tstate_e m_st = TS_STOP;
  int      m_rem = 0, m_cnt = 0, m_done = 0;
  logic    m_pstart = 1'b0, m_primed = 1'b0;
  logic [1:0] m_pph = 2'b00;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d (cycle %0d)", tag, obs, exp, ccount);
    end
  endtask

  task automatic model_reset();
    m_st = TS_STOP; m_rem = 0; m_cnt = 0; m_done = 0;
    m_pstart = 1'b0; m_pph = 2'b00; m_primed = 1'b0;
  endtask

  task automatic model_step();
    bit ld;
    int v;
    ld = start_timer && m_primed && (!m_pstart || phase != m_pph);
    v  = (phase == 2'b01) ? int'(work_secs) : (phase == 2'b10) ? int'(rest_secs) : 0;
    if (v > 99) v = 99;
    m_done = 0;
    if (!start_timer) begin
      m_st = TS_STOP; m_rem = 0; m_cnt = 0;
    end else if (ld) begin
      m_rem = v; m_cnt = 0;
      if (v == 0) begin m_st = TS_EXPIRED; m_done = 1; end
      else m_st = pause ? TS_PAUSED : TS_RUN;
    end else if (m_st == TS_RUN) begin
      if (m_cnt == 3) begin
        m_cnt = 0;
        if (m_rem == 1) begin m_rem = 0; m_done = 1; m_st = TS_EXPIRED; end
        else begin m_rem--; if (pause) m_st = TS_PAUSED; end
      end else begin
        m_cnt++;
        if (pause) m_st = TS_PAUSED;
      end
    end else if (m_st == TS_PAUSED && !pause) begin
      m_st = TS_RUN;
    end
    m_pstart = start_timer; m_pph = phase; m_primed = 1'b1;
  endtask

  task automatic cyc(input logic s, input logic [1:0] ph, input logic [7:0] w,
                     input logic [7:0] r, input logic p);
    exp_t e, g;
    @(negedge clk);
    start_timer = s; phase = ph; work_secs = w; rest_secs = r; pause = p;
    model_step();
    e.rem  = m_rem;
    e.done = m_done;
    e.run  = (m_st == TS_RUN);
    e.warn = ((m_st == TS_RUN || m_st == TS_PAUSED) && m_rem >= 1 && m_rem <= 3);
    sb.push_back(e);
    @(posedge clk); #1;
    ccount++;
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      g = sb.pop_front();
      chk("remaining", int'(remaining), g.rem);
      chk("sec_tens",  int'(sec_tens), g.rem / 10);
      chk("sec_ones",  int'(sec_ones), g.rem % 10);
      chk("time_done", int'(time_done), g.done);
      chk("warn",      int'(warn), g.warn);
      chk("running",   int'(running), g.run);
    end
    if (time_done) begin
      pulses++;
      if (done_cyc < 0) done_cyc = ccount;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_digits", int'({sec_tens, sec_ones}), 0);
    chk("rst_done_warn_run", int'({time_done, warn, running}), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int L;
    logic rs, rp;
    logic [1:0] rph;
    logic [7:0] rw, rr;

    #12;
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_done_warn_run", int'({time_done, warn, running}), 0);
    @(negedge clk); reset = 1'b0;
    model_reset();
    repeat (3) cyc(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);

    // basic 5 s workout: one pulse, 20 cycles after load
    cyc(1'b1, 2'b01, 8'd5, 8'd0, 1'b0);
    L = ccount; done_cyc = -1; pulses = 0;
    repeat (28) cyc(1'b1, 2'b01, 8'd5, 8'd0, 1'b0);
    chk("expire_latency", done_cyc - L, 20);
    chk("pulse_count", pulses, 1);

    // phase change mid-count reloads rest interval, crosses 10 -> 09
    cyc(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    cyc(1'b1, 2'b01, 8'd15, 8'd12, 1'b0);
    repeat (6) cyc(1'b1, 2'b01, 8'd15, 8'd12, 1'b0);
    pulses = 0;
    cyc(1'b1, 2'b10, 8'd15, 8'd12, 1'b0);
    chk("rest_reload_digits", int'({sec_tens, sec_ones}), 8'h12);
    repeat (14) cyc(1'b1, 2'b10, 8'd15, 8'd12, 1'b0);
    chk("rest_no_done", pulses, 0);

    // saturation, zero-length load and FINISH phase
    cyc(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    cyc(1'b1, 2'b01, 8'd150, 8'd0, 1'b0);
    chk("sat_digits", int'({sec_tens, sec_ones}), 8'h99);
    repeat (5) cyc(1'b1, 2'b01, 8'd150, 8'd0, 1'b0);
    cyc(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    cyc(1'b1, 2'b01, 8'd0, 8'd0, 1'b0);
    chk("zero_load_done", int'(time_done), 1);
    repeat (3) cyc(1'b1, 2'b01, 8'd0, 8'd0, 1'b0);
    cyc(1'b1, 2'b11, 8'd7, 8'd7, 1'b0);
    repeat (2) cyc(1'b1, 2'b11, 8'd7, 8'd7, 1'b0);

    // pause for 6 cycles at remaining 4 delays expiry by exactly 6
    cyc(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    cyc(1'b1, 2'b01, 8'd5, 8'd0, 1'b0);
    L = ccount; done_cyc = -1; pulses = 0;
    repeat (4) cyc(1'b1, 2'b01, 8'd5, 8'd0, 1'b0);
    chk("pause_at_4", int'(remaining), 4);
    repeat (6) cyc(1'b1, 2'b01, 8'd5, 8'd0, 1'b1);
    chk("paused_not_running", int'(running), 0);
    repeat (24) cyc(1'b1, 2'b01, 8'd5, 8'd0, 1'b0);
    chk("pause_latency", done_cyc - L, 26);
    chk("pause_pulse_count", pulses, 1);

    // reset mid-count at 7; held start must not restart
    cyc(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    cyc(1'b1, 2'b01, 8'd9, 8'd0, 1'b0);
    repeat (8) cyc(1'b1, 2'b01, 8'd9, 8'd0, 1'b0);
    chk("pre_reset_7", int'(remaining), 7);
    do_reset();
    repeat (10) cyc(1'b1, 2'b01, 8'd9, 8'd0, 1'b0);
    chk("held_start_no_count", int'({remaining, running}), 0);
    cyc(1'b1, 2'b10, 8'd9, 8'd6, 1'b0);
    chk("phase_change_loads", int'(remaining), 6);

    // start drops exactly on the final tick
    cyc(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
    cyc(1'b1, 2'b01, 8'd2, 8'd0, 1'b0);
    repeat (7) cyc(1'b1, 2'b01, 8'd2, 8'd0, 1'b0);
    chk("at_1_before_tick", int'(remaining), 1);
    pulses = 0;
    cyc(1'b0, 2'b01, 8'd2, 8'd0, 1'b0);
    repeat (2) cyc(1'b0, 2'b01, 8'd2, 8'd0, 1'b0);
    chk("stop_no_done", pulses, 0);

    // random traffic against the model
    rs = 1'b0; rph = 2'b01; rw = 8'd3; rr = 8'd2; rp = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) rs = ~rs;
      if ($urandom_range(0, 30) == 0) rph = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) rp = ~rp;
      rw = ($urandom_range(0, 15) == 0) ? 8'd200 : 8'($urandom_range(0, 6));
      rr = 8'($urandom_range(0, 12));
      cyc(rs, rph, rw, rr, rp);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
